// File: rtl/dtc_cs_frame_gen.sv
// dtc_cs_frame_gen
// DVP transmit frame generator. Pops one byte per beat from the DMA half-pixel
// stream and drives DVP timing in this order: VSYNC pulse, vertical blank,
// then img_height HREF lines of 2*img_width bytes separated by horizontal blanks.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   bwd_hpxl_*            upstream byte stream (dat/last/vld in, rdy out)
//   dvp_vsync/href/d      registered DVP outputs
//   cam_tx_en/mode/start  control: mode 0 sleep, 1 single-shot, 2 stream
//   cam_tx_start_qed      one-cycle pop of the start queue (single-shot only)
//   cam_tx_state          current FSM state (SLEEP=0 .. FLUSH=6)
//   img_width/img_height  frame size in pixels (>=1)
//   vsync/vblank/hblank_len  blanking lengths in cycles (0 behaves as 1)
//   irq_msk_frm_comp/err  enables for irq (frame done) and trap (frame error)
//
// Optional feature macro: DTC_TEST_PATTERN_EN adds input cam_tx_tpg. When it is
// high at VSYNC entry, the frame is generated internally as x ^ y and the
// upstream stream is left untouched.
//
// Handshake: a byte transfers on every clock edge where bwd_hpxl_vld and
// bwd_hpxl_rdy are both high. rdy is derived only from registered state and
// never depends on vld; the upstream side must hold dat/last stable while vld
// is high and rdy is low.
module dtc_cs_frame_gen #(
    parameter int DVP_DATA_W  = 8,
    parameter int IMG_DIM_MAX = 640,
    parameter int IMG_DIM_W   = $clog2(IMG_DIM_MAX),
    parameter int BLANK_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DVP_DATA_W-1:0] bwd_hpxl_dat,
    input  logic                  bwd_hpxl_last,
    input  logic                  bwd_hpxl_vld,
    output logic                  bwd_hpxl_rdy,
    output logic                  dvp_vsync,
    output logic                  dvp_href,
    output logic [DVP_DATA_W-1:0] dvp_d,
    input  logic                  cam_tx_en,
    input  logic [1:0]            cam_tx_mode,
    input  logic                  cam_tx_start,
    output logic                  cam_tx_start_qed,
    output logic [2:0]            cam_tx_state,
    input  logic [IMG_DIM_W-1:0]  img_width,
    input  logic [IMG_DIM_W-1:0]  img_height,
    input  logic [BLANK_W-1:0]    vsync_len,
    input  logic [BLANK_W-1:0]    vblank_len,
    input  logic [BLANK_W-1:0]    hblank_len,
    input  logic                  irq_msk_frm_comp,
    input  logic                  irq_msk_frm_err,
`ifdef DTC_TEST_PATTERN_EN
    input  logic                  cam_tx_tpg,
`endif
    output logic                  irq,
    output logic                  trap
);

    typedef enum logic [2:0] {
        ST_SLEEP  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_VSYNC  = 3'd2,
        ST_VBLANK = 3'd3,
        ST_LINE   = 3'd4,
        ST_HBLANK = 3'd5,
        ST_FLUSH  = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [BLANK_W-1:0]     bcnt_q, bcnt_d;
    logic [IMG_DIM_W:0]     x_q, x_d;
    logic [IMG_DIM_W-1:0]   y_q, y_d;
    logic                   err_uf_q, err_uf_d;
    logic                   err_sync_q, err_sync_d;
    logic                   drop_q, drop_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   vsync_q, vsync_d;
    logic                   href_q, href_d;
    logic [DVP_DATA_W-1:0]  d_q, d_d;
    logic                   irq_q, irq_d;
    logic                   trap_q, trap_d;
    logic                   qed_q, qed_d;

    logic                   tpg_q;
    logic                   start_frame;
    logic                   start_ok;
    logic                   rdy_int;
    logic                   hs;
    logic                   uf_set, sync_set;
    logic                   line_end, frame_end;
    logic [IMG_DIM_W:0]     line_last;
    logic [BLANK_W-1:0]     vs_last, vb_last, hb_last, blank_last;

    // Last bcnt value of each blank; a programmed length of 0 behaves as 1.
    assign vs_last = (vsync_len  == '0) ? '0 : vsync_len  - BLANK_W'(1);
    assign vb_last = (vblank_len == '0) ? '0 : vblank_len - BLANK_W'(1);
    assign hb_last = (hblank_len == '0) ? '0 : hblank_len - BLANK_W'(1);
    assign blank_last = (state_q == ST_VBLANK) ? vb_last : hb_last;

    assign line_last = {img_width, 1'b0} - (IMG_DIM_W+1)'(1);
    assign line_end  = (x_q == line_last);
    assign frame_end = line_end && (y_q == img_height - IMG_DIM_W'(1));

    assign start_ok = cam_tx_en && cam_tx_start && (cam_tx_mode != 2'd0);

    // After an early last the rest of the frame belongs to the next upstream
    // frame, so the line stops consuming and pads with zeros instead.
    assign rdy_int = ((state_q == ST_LINE) && !drop_q && !tpg_q) || (state_q == ST_FLUSH);
    assign hs      = rdy_int && bwd_hpxl_vld;

`ifdef DTC_TEST_PATTERN_EN
    logic tpg_d;

    always_comb begin
        tpg_d = tpg_q;
        if (start_frame) tpg_d = cam_tx_tpg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tpg_q <= 1'b0;
        else        tpg_q <= tpg_d;
    end
`else
    assign tpg_q = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        x_d          = x_q;
        y_d          = y_q;
        err_uf_d     = err_uf_q;
        err_sync_d   = err_sync_q;
        drop_d       = drop_q;
        flush_pend_d = flush_pend_q;
        vsync_d      = 1'b0;
        href_d       = 1'b0;
        d_d          = '0;
        irq_d        = 1'b0;
        qed_d        = 1'b0;
        start_frame  = 1'b0;
        uf_set       = 1'b0;
        sync_set     = 1'b0;

        case (state_q)
            ST_SLEEP, ST_IDLE: begin
                if ((state_q == ST_IDLE) && flush_pend_q) begin
                    state_d = ST_FLUSH;
                end else if (start_ok) begin
                    state_d     = ST_VSYNC;
                    start_frame = 1'b1;
                    qed_d       = (cam_tx_mode == 2'd1);
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            ST_VSYNC: begin
                vsync_d = 1'b1;
                if (bcnt_q == vs_last) begin
                    bcnt_d  = '0;
                    state_d = ST_VBLANK;
                end else begin
                    bcnt_d = bcnt_q + BLANK_W'(1);
                end
            end
            ST_VBLANK, ST_HBLANK: begin
                // Once the programmed blank has elapsed, hold here until the
                // first byte of the line is available.
                if (bcnt_q == blank_last) begin
                    if (bwd_hpxl_vld || tpg_q || drop_q) state_d = ST_LINE;
                end else begin
                    bcnt_d = bcnt_q + BLANK_W'(1);
                end
            end
            ST_LINE: begin
                href_d = 1'b1;
                x_d    = x_q + (IMG_DIM_W+1)'(1);
                if (tpg_q) begin
                    d_d = x_q[DVP_DATA_W-1:0] ^ y_q[DVP_DATA_W-1:0];
                end else if (drop_q) begin
                    d_d = '0;
                end else if (bwd_hpxl_vld) begin
                    d_d = bwd_hpxl_dat;
                    if (bwd_hpxl_last && !frame_end) begin
                        sync_set = 1'b1;
                        drop_d   = 1'b1;
                    end
                    if (!bwd_hpxl_last && frame_end) begin
                        sync_set     = 1'b1;
                        flush_pend_d = 1'b1;
                    end
                end else begin
                    uf_set = 1'b1;
                end
                if (line_end) begin
                    x_d = '0;
                    if (frame_end) begin
                        state_d = ST_IDLE;
                        irq_d   = irq_msk_frm_comp;
                    end else begin
                        y_d     = y_q + IMG_DIM_W'(1);
                        bcnt_d  = '0;
                        state_d = ST_HBLANK;
                    end
                end
            end
            ST_FLUSH: begin
                if (hs && bwd_hpxl_last) begin
                    flush_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_SLEEP;
        endcase

        if (start_frame) begin
            bcnt_d     = '0;
            x_d        = '0;
            y_d        = '0;
            err_uf_d   = 1'b0;
            err_sync_d = 1'b0;
            drop_d     = 1'b0;
        end
        if (uf_set)   err_uf_d   = 1'b1;
        if (sync_set) err_sync_d = 1'b1;

        // Only the first error of a frame raises trap.
        trap_d = irq_msk_frm_err && (uf_set || sync_set) && !(err_uf_q || err_sync_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SLEEP;
            bcnt_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            err_uf_q     <= 1'b0;
            err_sync_q   <= 1'b0;
            drop_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= '0;
            irq_q        <= 1'b0;
            trap_q       <= 1'b0;
            qed_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            err_uf_q     <= err_uf_d;
            err_sync_q   <= err_sync_d;
            drop_q       <= drop_d;
            flush_pend_q <= flush_pend_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            d_q          <= d_d;
            irq_q        <= irq_d;
            trap_q       <= trap_d;
            qed_q        <= qed_d;
        end
    end

    assign bwd_hpxl_rdy     = rdy_int;
    assign dvp_vsync        = vsync_q;
    assign dvp_href         = href_q;
    assign dvp_d            = d_q;
    assign irq              = irq_q;
    assign trap             = trap_q;
    assign cam_tx_start_qed = qed_q;
    assign cam_tx_state     = state_q;

endmodule

// File: tb/tb_dtc_cs_frame_gen.sv
module tb_dtc_cs_frame_gen;

    localparam int DW = 8;
    localparam int IW = 10;
    localparam int BW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] bwd_hpxl_dat;
    logic          bwd_hpxl_last;
    logic          bwd_hpxl_vld;
    logic          bwd_hpxl_rdy;
    logic          dvp_vsync;
    logic          dvp_href;
    logic [DW-1:0] dvp_d;
    logic          cam_tx_en;
    logic [1:0]    cam_tx_mode;
    logic          cam_tx_start;
    logic          cam_tx_start_qed;
    logic [2:0]    cam_tx_state;
    logic [IW-1:0] img_width;
    logic [IW-1:0] img_height;
    logic [BW-1:0] vsync_len;
    logic [BW-1:0] vblank_len;
    logic [BW-1:0] hblank_len;
    logic          irq_msk_frm_comp;
    logic          irq_msk_frm_err;
    logic          irq;
    logic          trap;

    dtc_cs_frame_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bwd_hpxl_dat     (bwd_hpxl_dat),
        .bwd_hpxl_last    (bwd_hpxl_last),
        .bwd_hpxl_vld     (bwd_hpxl_vld),
        .bwd_hpxl_rdy     (bwd_hpxl_rdy),
        .dvp_vsync        (dvp_vsync),
        .dvp_href         (dvp_href),
        .dvp_d            (dvp_d),
        .cam_tx_en        (cam_tx_en),
        .cam_tx_mode      (cam_tx_mode),
        .cam_tx_start     (cam_tx_start),
        .cam_tx_start_qed (cam_tx_start_qed),
        .cam_tx_state     (cam_tx_state),
        .img_width        (img_width),
        .img_height       (img_height),
        .vsync_len        (vsync_len),
        .vblank_len       (vblank_len),
        .hblank_len       (hblank_len),
        .irq_msk_frm_comp (irq_msk_frm_comp),
        .irq_msk_frm_err  (irq_msk_frm_err),
        .irq              (irq),
        .trap             (trap)
    );

    // ---------------- source model state ----------------
    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    beat_t src_q[$];
    int    src_idx;
    int    gap_idx;
    int    gap_len;
    int    gap_cnt;
    logic  fire;

    // ---------------- monitor / scoreboard ----------------
    logic [DW-1:0] obs_q[$];
    logic [DW-1:0] exp_q[$];
    int   runs_q[$];
    int   gaps_q[$];
    int   vs_cyc, irq_cnt, trap_cnt, qed_cnt, flush_pops, idle_vs, line_rdy;
    int   vb_gap, vb_cnt, run_len, low_len, n_runs;
    logic href_prev, vs_prev, vs_fell;
    logic [7:0] seen_mask;
    logic [2:0] st_prev;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        obs_q.delete();
        exp_q.delete();
        runs_q.delete();
        gaps_q.delete();
        vs_cyc = 0; irq_cnt = 0; trap_cnt = 0; qed_cnt = 0;
        flush_pops = 0; idle_vs = 0; line_rdy = 0;
        vb_gap = -1; vb_cnt = 0; run_len = 0; low_len = 0; n_runs = 0;
        href_prev = 1'b0; vs_prev = 1'b0; vs_fell = 1'b0;
        seen_mask = '0; st_prev = '0;
        src_idx = 0; gap_idx = -1; gap_len = 0; gap_cnt = 0;
    endtask

    // One clock: sample outputs at the falling edge, then update the
    // upstream source 1ns after the rising edge.
    task automatic step();
        @(negedge clk);
        if (dvp_vsync) vs_cyc++;
        if (vs_prev && !dvp_vsync) begin
            vs_fell = 1'b1;
            vb_cnt  = 0;
        end
        if (dvp_href) begin
            if (!href_prev) begin
                if (n_runs > 0) gaps_q.push_back(low_len);
                else if (vs_fell) vb_gap = vb_cnt;
                n_runs++;
                run_len = 0;
            end
            run_len++;
            obs_q.push_back(dvp_d);
        end else begin
            if (href_prev) begin
                runs_q.push_back(run_len);
                low_len = 0;
            end
            low_len++;
            if (vs_fell && !dvp_vsync) vb_cnt++;
        end
        href_prev = dvp_href;
        vs_prev   = dvp_vsync;
        irq_cnt  += int'(irq);
        trap_cnt += int'(trap);
        qed_cnt  += int'(cam_tx_start_qed);
        seen_mask[cam_tx_state] = 1'b1;
        if (st_prev == 3'd1 && cam_tx_state == 3'd2) idle_vs++;
        st_prev = cam_tx_state;
        fire = bwd_hpxl_vld && bwd_hpxl_rdy;
        if (fire && cam_tx_state == 3'd6) flush_pops++;
        if (bwd_hpxl_rdy && cam_tx_state == 3'd4) line_rdy++;

        @(posedge clk);
        #1;
        if (fire && src_q.size() > 0) begin
            void'(src_q.pop_front());
            src_idx++;
            if (src_idx == gap_idx) gap_cnt = gap_len;
        end
        if (gap_cnt > 0) begin
            gap_cnt--;
            bwd_hpxl_vld = 1'b0;
        end else if (src_q.size() > 0) begin
            bwd_hpxl_vld  = 1'b1;
            bwd_hpxl_dat  = src_q[0].dat;
            bwd_hpxl_last = src_q[0].last;
        end else begin
            bwd_hpxl_vld  = 1'b0;
            bwd_hpxl_dat  = '0;
            bwd_hpxl_last = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_bytes(input int n, input int last_a, input int last_b);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.dat  = 8'(8'h10 + i);
            b.last = (i == last_a) || (i == last_b);
            src_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input logic [1:0] mode);
        cam_tx_mode  = mode;
        cam_tx_start = 1'b1;
        step();
        cam_tx_start = 1'b0;
    endtask

    task automatic wait_frame(input int bound, input string tag);
        bit left = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            step();
            if (cam_tx_state != 3'd0) left = 1'b1;
            else if (left) done = 1'b1;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic chk_data(input string tag);
        chk({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic chk_lines(input string tag, input int nlines, input int len, input int gap);
        chk({tag, "_nlines"}, 32'(runs_q.size()), 32'(nlines));
        for (int i = 0; i < runs_q.size(); i++)
            chk($sformatf("%s_href%0d", tag, i), 32'(runs_q[i]), 32'(len));
        if (gap >= 0) begin
            chk({tag, "_ngaps"}, 32'(gaps_q.size()), 32'(nlines - 1));
            for (int i = 0; i < gaps_q.size(); i++)
                chk($sformatf("%s_hgap%0d", tag, i), 32'(gaps_q[i]), 32'(gap));
        end
    endtask

    // Clean 4x2 single-shot frame, continuous data.
    task automatic run_clean(input string tag);
        mon_clear();
        push_bytes(16, 15, -1);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
        pulse_start(2'd1);
        wait_frame(200, tag);
        chk({tag, "_vsync"}, 32'(vs_cyc), 32'd2);
        chk({tag, "_vblank"}, 32'(vb_gap), 32'd3);
        chk_lines(tag, 2, 8, 2);
        chk_data(tag);
        chk({tag, "_irq"}, 32'(irq_cnt), 32'd1);
        chk({tag, "_trap"}, 32'(trap_cnt), 32'd0);
        chk({tag, "_qed"}, 32'(qed_cnt), 32'd1);
        chk({tag, "_rdy"}, 32'(line_rdy), 32'd16);
        chk({tag, "_states"}, 32'(seen_mask), 32'h3f);
        chk({tag, "_state"}, 32'(cam_tx_state), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bwd_hpxl_dat     = '0;
        bwd_hpxl_last    = 1'b0;
        bwd_hpxl_vld     = 1'b0;
        cam_tx_en        = 1'b1;
        cam_tx_mode      = 2'd1;
        cam_tx_start     = 1'b0;
        img_width        = 10'd4;
        img_height       = 10'd2;
        vsync_len        = 8'd2;
        vblank_len       = 8'd3;
        hblank_len       = 8'd2;
        irq_msk_frm_comp = 1'b1;
        irq_msk_frm_err  = 1'b1;
        mon_clear();

        for (int i = 0; i < 3; i++) step();
        chk("rst_state", 32'(cam_tx_state), 32'd0);
        chk("rst_href", 32'(dvp_href), 32'd0);
        chk("rst_vsync", 32'(dvp_vsync), 32'd0);
        chk("rst_d", 32'(dvp_d), 32'd0);
        chk("rst_rdy", 32'(bwd_hpxl_rdy), 32'd0);
        chk("rst_irq_trap_qed", {29'd0, irq, trap, cam_tx_start_qed}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step();

        // T1: clean single-shot frame
        run_clean("t1");

        // T2: one-cycle underflow before the third byte; final slot then
        // carries a non-last byte, so the real last is flushed afterwards.
        mon_clear();
        push_bytes(16, 15, -1);
        gap_idx = 2;
        gap_len = 1;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h00);
        for (int i = 2; i < 15; i++) exp_q.push_back(8'(8'h10 + i));
        pulse_start(2'd1);
        wait_frame(200, "t2");
        chk_lines("t2", 2, 8, 2);
        chk_data("t2");
        chk("t2_irq", 32'(irq_cnt), 32'd1);
        chk("t2_trap", 32'(trap_cnt), 32'd1);
        chk("t2_flush", 32'(flush_pops), 32'd1);
        chk("t2_states", 32'(seen_mask), 32'h7f);
        chk("t2_srcleft", 32'(src_q.size()), 32'd0);

        // T3: last on the 10th byte; the rest of the frame is zero padding.
        mon_clear();
        push_bytes(10, 9, -1);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h00);
        pulse_start(2'd1);
        wait_frame(200, "t3");
        chk_lines("t3", 2, 8, 2);
        chk_data("t3");
        chk("t3_irq", 32'(irq_cnt), 32'd1);
        chk("t3_trap", 32'(trap_cnt), 32'd1);
        chk("t3_rdy", 32'(line_rdy), 32'd10);
        chk("t3_states", 32'(seen_mask), 32'h3f);

        // T4: last withheld, 3 extra bytes then last; zero-length vsync and
        // hblank behave as one cycle.
        mon_clear();
        vsync_len  = 8'd0;
        hblank_len = 8'd0;
        push_bytes(20, 19, -1);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
        pulse_start(2'd1);
        wait_frame(200, "t4");
        chk("t4_vsync", 32'(vs_cyc), 32'd1);
        chk_lines("t4", 2, 8, 1);
        chk_data("t4");
        chk("t4_irq", 32'(irq_cnt), 32'd1);
        chk("t4_trap", 32'(trap_cnt), 32'd1);
        chk("t4_flush", 32'(flush_pops), 32'd4);
        chk("t4_states", 32'(seen_mask), 32'h7f);
        chk("t4_srcleft", 32'(src_q.size()), 32'd0);
        vsync_len  = 8'd2;
        hblank_len = 8'd2;

        // T5: stream mode, start held through the first frame.
        begin
            bit got_irq = 1'b0;
            mon_clear();
            push_bytes(32, 15, 31);
            for (int i = 0; i < 32; i++) exp_q.push_back(8'(8'h10 + i));
            cam_tx_mode  = 2'd2;
            cam_tx_start = 1'b1;
            for (int i = 0; i < 200 && !got_irq; i++) begin
                step();
                if (irq_cnt == 1) got_irq = 1'b1;
            end
            chk("t5_irq1", 32'(got_irq), 32'd1);
            cam_tx_start = 1'b0;
            wait_frame(200, "t5");
            chk_lines("t5", 4, 8, -1);
            chk_data("t5");
            chk("t5_irq", 32'(irq_cnt), 32'd2);
            chk("t5_qed", 32'(qed_cnt), 32'd0);
            chk("t5_idle_vs", 32'(idle_vs), 32'd1);
            chk("t5_vsync", 32'(vs_cyc), 32'd4);
            chk("t5_trap", 32'(trap_cnt), 32'd0);
        end

        // T6: asynchronous reset in the middle of a line, then a clean frame.
        begin
            bit in_line = 1'b0;
            mon_clear();
            push_bytes(16, 15, -1);
            pulse_start(2'd1);
            for (int i = 0; i < 50 && !in_line; i++) begin
                step();
                if (cam_tx_state == 3'd4) in_line = 1'b1;
            end
            chk("t6_in_line", 32'(in_line), 32'd1);
            for (int i = 0; i < 3; i++) step();
            #2;
            chk("t6_pre_href", 32'(dvp_href), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("t6_href", 32'(dvp_href), 32'd0);
            chk("t6_vsync", 32'(dvp_vsync), 32'd0);
            chk("t6_d", 32'(dvp_d), 32'd0);
            chk("t6_state", 32'(cam_tx_state), 32'd0);
            chk("t6_irq_trap", {30'd0, irq, trap}, 32'd0);
            src_q.delete();
            gap_cnt = 0;
            for (int i = 0; i < 2; i++) step();
            rst_n = 1'b1;
            step();
            run_clean("t6r");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
